// File: rtl/muldiv_unit.sv
// muldiv_unit: RV32M-style multiply/divide unit for the execute stage.
// Iterative shift-add multiplier and restoring divider, one bit per cycle.
// Divide-by-zero and signed overflow finish in one cycle without iterating.
// Optional macro MULDIV_FAST_MUL_EN: multiplies use one combinational
// multiply and finish in one cycle. Division is iterative in both builds.
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | ready for a request, o_ready=1
// CALC  | iterating, one product/quotient bit per cycle for XLEN cycles
// DONE  | o_valid=1, result and tag held until i_out_ready
module muldiv_unit #(
  parameter int XLEN  = 32,
  parameter int TAG_W = 5
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_flush,
  input  logic             i_valid,
  output logic             o_ready,
  input  logic [6:0]       i_opcode,
  input  logic [6:0]       i_funct7,
  input  logic [2:0]       i_funct3,
  input  logic [XLEN-1:0]  i_rs1,
  input  logic [XLEN-1:0]  i_rs2,
  input  logic [TAG_W-1:0] i_tag,
  output logic             o_valid,
  input  logic             i_out_ready,
  output logic [XLEN-1:0]  o_result,
  output logic [TAG_W-1:0] o_tag,
  output logic             o_busy
);

  localparam int CNT_W = $clog2(XLEN) + 1;
  localparam logic [6:0] OPC_OP = 7'b0110011;
  localparam logic [6:0] F7_M   = 7'h01;
  localparam logic [XLEN-1:0] INT_MIN = {1'b1, {(XLEN-1){1'b0}}};

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_DONE} state_t;

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [2:0]          f3_q, f3_d;
  logic [TAG_W-1:0]    tag_q, tag_d;
  logic [XLEN-1:0]     op_q, op_d;     // multiplicand (mul) or divisor (div) magnitude
  logic [2*XLEN-1:0]   acc_q, acc_d;   // {hi, multiplier} or {remainder, quotient}
  logic                neg_q, neg_d;   // negate the selected result at the end
  logic [XLEN-1:0]     res_q, res_d;

  // ---------------- request decode ----------------
  logic            hs, accept;
  logic            is_div_in, a_signed_in, b_signed_in, sa_in, sb_in, neg_in;
  logic [XLEN-1:0] mag_a_in, mag_b_in;
  logic            div_zero_in, div_ovf_in, fast_in;
  logic [XLEN-1:0] div_fast_res, fast_res_in;

  assign o_ready = (state_q == S_IDLE);
  assign hs      = i_valid && o_ready && (i_opcode == OPC_OP) && (i_funct7 == F7_M);
  assign accept  = hs && !i_flush;

  assign is_div_in   = i_funct3[2];
  // MULH, MULHSU, DIV, REM take rs1 as signed; MULH, DIV, REM take rs2 as signed
  assign a_signed_in = (i_funct3 == 3'b001) || (i_funct3 == 3'b010) ||
                       (i_funct3 == 3'b100) || (i_funct3 == 3'b110);
  assign b_signed_in = (i_funct3 == 3'b001) || (i_funct3 == 3'b100) ||
                       (i_funct3 == 3'b110);
  assign sa_in    = a_signed_in && i_rs1[XLEN-1];
  assign sb_in    = b_signed_in && i_rs2[XLEN-1];
  assign mag_a_in = sa_in ? -i_rs1 : i_rs1;
  assign mag_b_in = sb_in ? -i_rs2 : i_rs2;
  // remainder follows the dividend sign; everything else is sign(a)^sign(b)
  assign neg_in   = (is_div_in && i_funct3[1]) ? sa_in : (sa_in ^ sb_in);

  assign div_zero_in  = is_div_in && (i_rs2 == '0);
  assign div_ovf_in   = is_div_in && !i_funct3[0] && (i_rs1 == INT_MIN) && (i_rs2 == '1);
  assign div_fast_res = div_zero_in ? (i_funct3[1] ? i_rs1 : '1)
                                    : (i_funct3[1] ? '0 : i_rs1);

`ifdef MULDIV_FAST_MUL_EN
  logic [2*XLEN-1:0] fm_a, fm_b, fm_p;
  logic [XLEN-1:0]   fm_res;
  // sign-extend each operand to 2*XLEN; the low 2*XLEN bits of the product are exact
  assign fm_a   = {{XLEN{sa_in}}, i_rs1};
  assign fm_b   = {{XLEN{sb_in}}, i_rs2};
  assign fm_p   = fm_a * fm_b;
  assign fm_res = (i_funct3 == 3'b000) ? fm_p[XLEN-1:0] : fm_p[2*XLEN-1:XLEN];
  assign fast_in     = div_zero_in || div_ovf_in || !is_div_in;
  assign fast_res_in = is_div_in ? div_fast_res : fm_res;
`else
  assign fast_in     = div_zero_in || div_ovf_in;
  assign fast_res_in = div_fast_res;
`endif

  // ---------------- iterative datapath ----------------
  logic              last;
  logic [XLEN:0]     mul_sum, rem_sh, rem_diff;
  logic [XLEN-1:0]   rem_nx;
  logic              q_bit;
  logic [2*XLEN-1:0] mul_nx, div_nx, mul_signed;
  logic [XLEN-1:0]   quo, rem, div_res, mul_res, final_res;

  assign last = (cnt_q == CNT_W'(XLEN - 1));

  // shift-add: add multiplicand into the high half when the multiplier LSB is set
  assign mul_sum = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, op_q} : '0);
  assign mul_nx  = {mul_sum, acc_q[XLEN-1:1]};

  // restoring divide: the partial remainder is always below the divisor,
  // so one extra bit is enough to hold the shifted value
  assign rem_sh   = {acc_q[2*XLEN-1:XLEN], acc_q[XLEN-1]};
  assign rem_diff = rem_sh - {1'b0, op_q};
  assign q_bit    = !rem_diff[XLEN];
  assign rem_nx   = q_bit ? rem_diff[XLEN-1:0] : rem_sh[XLEN-1:0];
  assign div_nx   = {rem_nx, acc_q[XLEN-2:0], q_bit};

  assign mul_signed = neg_q ? -mul_nx : mul_nx;
  assign mul_res    = (f3_q == 3'b000) ? mul_signed[XLEN-1:0] : mul_signed[2*XLEN-1:XLEN];
  assign quo        = div_nx[XLEN-1:0];
  assign rem        = div_nx[2*XLEN-1:XLEN];
  assign div_res    = f3_q[1] ? (neg_q ? -rem : rem) : (neg_q ? -quo : quo);
  assign final_res  = f3_q[2] ? div_res : mul_res;

  // FSM next state: flush wins over accept and retire
  always_comb begin
    state_d = state_q;
    if (i_flush) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: if (accept) state_d = fast_in ? S_DONE : S_CALC;
        S_CALC: if (last) state_d = S_DONE;
        S_DONE: if (i_out_ready) state_d = S_IDLE;
        default: state_d = S_IDLE;
      endcase
    end
  end

  // datapath next values: load on accept, step once per CALC cycle
  always_comb begin
    cnt_d = cnt_q;
    f3_d  = f3_q;
    tag_d = tag_q;
    op_d  = op_q;
    acc_d = acc_q;
    neg_d = neg_q;
    res_d = res_q;
    if (accept) begin
      cnt_d = '0;
      f3_d  = i_funct3;
      tag_d = i_tag;
      neg_d = neg_in;
      if (is_div_in) begin
        op_d  = mag_b_in;
        acc_d = {{XLEN{1'b0}}, mag_a_in};
      end else begin
        op_d  = mag_a_in;
        acc_d = {{XLEN{1'b0}}, mag_b_in};
      end
      if (fast_in) res_d = fast_res_in;
    end else if ((state_q == S_CALC) && !i_flush) begin
      acc_d = f3_q[2] ? div_nx : mul_nx;
      cnt_d = cnt_q + CNT_W'(1);
      if (last) res_d = final_res;
    end
  end

  // state and datapath registers with synchronous active-low reset
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      f3_q    <= '0;
      tag_q   <= '0;
      op_q    <= '0;
      acc_q   <= '0;
      neg_q   <= 1'b0;
      res_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      f3_q    <= f3_d;
      tag_q   <= tag_d;
      op_q    <= op_d;
      acc_q   <= acc_d;
      neg_q   <= neg_d;
      res_q   <= res_d;
    end
  end

  assign o_valid  = (state_q == S_DONE);
  assign o_busy   = (state_q != S_IDLE);
  assign o_result = res_q;
  assign o_tag    = tag_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed testbench for muldiv_unit (XLEN=32, TAG_W=5).
// Honours MULDIV_FAST_MUL_EN for the expected multiply latency.
module tb_muldiv_unit;

  localparam logic [6:0] OPC_OP = 7'b0110011;

`ifdef MULDIV_FAST_MUL_EN
  localparam int MUL_LAT = 1;
`else
  localparam int MUL_LAT = 33;
`endif
  localparam int DIV_LAT  = 33;
  localparam int FAST_LAT = 1;

  logic        i_clk = 1'b0;
  logic        i_rst_n, i_flush, i_valid, o_ready, o_valid, i_out_ready, o_busy;
  logic [6:0]  i_opcode, i_funct7;
  logic [2:0]  i_funct3;
  logic [31:0] i_rs1, i_rs2, o_result;
  logic [4:0]  i_tag, o_tag;

  int n_checks = 0;
  int n_fail   = 0;

  muldiv_unit #(.XLEN(32), .TAG_W(5)) dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_flush(i_flush), .i_valid(i_valid),
    .o_ready(o_ready), .i_opcode(i_opcode), .i_funct7(i_funct7), .i_funct3(i_funct3),
    .i_rs1(i_rs1), .i_rs2(i_rs2), .i_tag(i_tag), .o_valid(o_valid),
    .i_out_ready(i_out_ready), .o_result(o_result), .o_tag(o_tag), .o_busy(o_busy)
  );

  always #5 i_clk = ~i_clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // present a request for one edge; returns #1 after the handshake edge (cycle 1)
  task automatic issue(input logic [6:0] f7, input logic [2:0] f3,
                       input logic [31:0] a, input logic [31:0] b, input logic [4:0] t);
    i_opcode = OPC_OP;
    i_funct7 = f7;
    i_funct3 = f3;
    i_rs1    = a;
    i_rs2    = b;
    i_tag    = t;
    i_valid  = 1'b1;
    @(posedge i_clk);
    #1 i_valid = 1'b0;
  endtask

  task automatic wait_valid(output int cyc);
    cyc = 1;
    while (!o_valid && cyc < 100) begin
      @(posedge i_clk);
      #1 cyc++;
    end
  endtask

  task automatic retire(input string name);
    i_out_ready = 1'b1;
    @(posedge i_clk);
    #1 i_out_ready = 1'b0;
    check({name, "_ready_after"}, 64'(o_ready), 64'd1);
  endtask

  task automatic run_op(input string name, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] b, input logic [4:0] t,
                        input logic [31:0] exp, input int exp_lat);
    int cyc;
    issue(7'h01, f3, a, b, t);
    wait_valid(cyc);
    check({name, "_valid"}, 64'(o_valid), 64'd1);
    check({name, "_lat"}, 64'(cyc), 64'(exp_lat));
    check({name, "_res"}, 64'(o_result), 64'(exp));
    check({name, "_tag"}, 64'(o_tag), 64'(t));
    retire(name);
  endtask

  initial begin
    int cyc;
    logic [31:0] held_res;
    logic        saw_valid;
    i_rst_n = 1'b0; i_flush = 1'b0; i_valid = 1'b0; i_out_ready = 1'b0;
    i_opcode = '0; i_funct7 = '0; i_funct3 = '0; i_rs1 = '0; i_rs2 = '0; i_tag = '0;
    repeat (3) @(posedge i_clk);
    #1 i_rst_n = 1'b1;

    check("rst_ready",  64'(o_ready),  64'd1);
    check("rst_valid",  64'(o_valid),  64'd0);
    check("rst_busy",   64'(o_busy),   64'd0);
    check("rst_result", 64'(o_result), 64'd0);
    check("rst_tag",    64'(o_tag),    64'd0);

    run_op("mul",    3'b000, 32'd7,        32'hFFFF_FFFD, 5'd5,  32'hFFFF_FFEB, MUL_LAT);
    run_op("mulh",   3'b001, 32'h8000_0000, 32'h8000_0000, 5'd1,  32'h4000_0000, MUL_LAT);
    run_op("mulhsu", 3'b010, 32'h8000_0000, 32'h8000_0000, 5'd2,  32'hC000_0000, MUL_LAT);
    run_op("mulhu",  3'b011, 32'h8000_0000, 32'h8000_0000, 5'd3,  32'h4000_0000, MUL_LAT);
    run_op("mul2",   3'b000, 32'h0001_0003, 32'h0002_0005, 5'd4,  32'h000B_000F, MUL_LAT);

    run_op("div",    3'b100, 32'hFFFF_FFF9, 32'd2, 5'd6,  32'hFFFF_FFFD, DIV_LAT);
    run_op("rem",    3'b110, 32'hFFFF_FFF9, 32'd2, 5'd7,  32'hFFFF_FFFF, DIV_LAT);
    run_op("divu",   3'b101, 32'd20,        32'd3, 5'd8,  32'd6,         DIV_LAT);
    run_op("remu",   3'b111, 32'd20,        32'd3, 5'd9,  32'd2,         DIV_LAT);
    run_op("div_pn", 3'b100, 32'd100,  32'hFFFF_FFF9, 5'd10, 32'hFFFF_FFF2, DIV_LAT);

    run_op("divu_z", 3'b101, 32'd5,         32'd0,         5'd11, 32'hFFFF_FFFF, FAST_LAT);
    run_op("remu_z", 3'b111, 32'd5,         32'd0,         5'd12, 32'd5,         FAST_LAT);
    run_op("div_z",  3'b100, 32'hFFFF_FFF9, 32'd0,         5'd13, 32'hFFFF_FFFF, FAST_LAT);
    run_op("rem_z",  3'b110, 32'hFFFF_FFF9, 32'd0,         5'd14, 32'hFFFF_FFF9, FAST_LAT);
    run_op("div_ov", 3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 5'd15, 32'h8000_0000, FAST_LAT);
    run_op("rem_ov", 3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 5'd16, 32'd0,         FAST_LAT);

    // backpressure: result and tag held while the consumer stalls
    issue(7'h01, 3'b101, 32'd20, 32'd3, 5'd17);
    wait_valid(cyc);
    check("bp_lat", 64'(cyc), 64'(DIV_LAT));
    for (int i = 0; i < 10; i++) begin
      @(posedge i_clk);
      #1;
      check("bp_valid", 64'(o_valid),  64'd1);
      check("bp_res",   64'(o_result), 64'd6);
      check("bp_tag",   64'(o_tag),    64'd17);
      check("bp_ready", 64'(o_ready),  64'd0);
    end
    retire("bp");

    // flush in CALC cycle 10: no result, then a fresh op completes normally
    issue(7'h01, 3'b101, 32'd100, 32'd7, 5'd18);
    repeat (9) @(posedge i_clk);
    #1 check("fl_busy_pre", 64'(o_busy), 64'd1);
    i_flush = 1'b1;
    @(posedge i_clk);
    #1 i_flush = 1'b0;
    check("fl_busy",  64'(o_busy),  64'd0);
    check("fl_ready", 64'(o_ready), 64'd1);
    saw_valid = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(posedge i_clk);
      #1 if (o_valid) saw_valid = 1'b1;
    end
    check("fl_no_valid", 64'(saw_valid), 64'd0);
    run_op("fl_divu", 3'b101, 32'd9, 32'd3, 5'd19, 32'd3, DIV_LAT);

    // flush concurrent with a handshake drops the request
    i_flush = 1'b1;
    issue(7'h01, 3'b101, 32'd9, 32'd0, 5'd20);
    i_flush = 1'b0;
    check("flhs_busy", 64'(o_busy), 64'd0);

    // flush wins over retire in DONE
    issue(7'h01, 3'b111, 32'd5, 32'd0, 5'd21);
    check("fldone_valid", 64'(o_valid), 64'd1);
    i_flush = 1'b1;
    i_out_ready = 1'b1;
    @(posedge i_clk);
    #1 i_flush = 1'b0;
    i_out_ready = 1'b0;
    check("fldone_gone",  64'(o_valid), 64'd0);
    check("fldone_ready", 64'(o_ready), 64'd1);

    // non-M encoding is ignored
    i_opcode = OPC_OP; i_funct7 = 7'h00; i_funct3 = 3'b000;
    i_rs1 = 32'd1; i_rs2 = 32'd2; i_tag = 5'd22; i_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge i_clk);
      #1;
      check("add_busy",  64'(o_busy),  64'd0);
      check("add_valid", 64'(o_valid), 64'd0);
    end
    i_valid = 1'b0;

    // reset mid-operation clears result and tag
    held_res = o_result;
    check("pre_rst_res", 64'(held_res), 64'd5);
    issue(7'h01, 3'b101, 32'd9, 32'd3, 5'd23);
    repeat (5) @(posedge i_clk);
    #1 i_rst_n = 1'b0;
    @(posedge i_clk);
    #1 i_rst_n = 1'b1;
    check("mrst_busy",   64'(o_busy),   64'd0);
    check("mrst_result", 64'(o_result), 64'd0);
    check("mrst_tag",    64'(o_tag),    64'd0);
    check("mrst_ready",  64'(o_ready),  64'd1);
    run_op("post_rst", 3'b000, 32'd12, 32'd13, 5'd24, 32'd156, MUL_LAT);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
